ram_cmd_master: RTL and testbench

Command initiator for the single-port RAM's 10-bit word interface. Accepts one read or write request at a time on a valid/ready front end, issues the two-word command sequence to the RAM (address word, then data or read word), and captures the RAM's `tx_valid`/`dout` reply. It returns a single-cycle response per request, with a timeout error if the RAM never answers a read. It sits where the SPI slave front end sits today, so the RAM can be driven from an on-chip host.

---
 rtl/RAM_pkg.sv | 21 ++
 rtl/ram_rd_timeout.sv | 27 ++
 rtl/ram_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_ram_cmd_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/RAM_pkg.sv
// Shared RAM command definitions: word command codes and the command-master FSM states.
package RAM_pkg;

    typedef enum logic [1:0] {
        STORE_WR_ADDR = 2'b00,
        WRITE_DATA    = 2'b01,
        STORE_RD_ADDR = 2'b10,
        READ_DATA     = 2'b11
    } signal_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT,
        RESP
    } ram_cmd_state_e;

endpackage

// File: rtl/ram_rd_timeout.sv
// Wait counter for the read-reply window; expired flags the cycle whose
// increment brings the count to TIMEOUT.
module ram_rd_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_cmd_master.sv
// On-chip command initiator for the single-port RAM word interface.
// Optional last-address caching is enabled by defining RAM_CMD_ADDR_CACHE_EN.
module ram_cmd_master
    import RAM_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 rx_valid,
    output logic [ADDR_SIZE+1:0] din,
    input  logic                 tx_valid,
    input  logic [ADDR_SIZE-1:0] dout
);

    ram_cmd_state_e state, next_state;

    logic [ADDR_SIZE-1:0] addr_q, wdata_q;
    logic [ADDR_SIZE-1:0] cur_addr, cur_wdata;
    logic                 accept;
    logic                 wr_hit, rd_hit;
    logic                 wait_en, wait_clear, expired;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // The first word leaves on the acceptance edge, before addr_q/wdata_q are visible.
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef RAM_CMD_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] wr_cache_addr, rd_cache_addr;
    logic                 wr_cache_vld, rd_cache_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cache_vld <= 1'b0;
            rd_cache_vld <= 1'b0;
        end else begin
            if (state == IDLE && next_state == WR_ADDR) begin
                wr_cache_vld  <= 1'b1;
                wr_cache_addr <= req_addr;
            end
            if (state == IDLE && next_state == RD_ADDR) begin
                rd_cache_vld  <= 1'b1;
                rd_cache_addr <= req_addr;
            end
        end
    end

    assign wr_hit = wr_cache_vld && (wr_cache_addr == req_addr);
    assign rd_hit = rd_cache_vld && (rd_cache_addr == req_addr);
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    assign wait_en    = (state == RD_WAIT) && !tx_valid;
    assign wait_clear = (state != RD_WAIT);

    ram_rd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .en      (wait_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        next_state = wr_hit ? WR_DATA : WR_ADDR;
                    end else begin
                        next_state = rd_hit ? RD_CMD : RD_ADDR;
                    end
                end
            end
            WR_ADDR: next_state = WR_DATA;
            WR_DATA: next_state = RESP;
            RD_ADDR: next_state = RD_CMD;
            RD_CMD:  next_state = RD_WAIT;
            RD_WAIT: begin
                if (tx_valid || expired) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the state being entered so each word lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid  <= 1'b0;
            din       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rx_valid  <= 1'b0;
            din       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (next_state)
                WR_ADDR: begin
                    rx_valid <= 1'b1;
                    din      <= {STORE_WR_ADDR, cur_addr};
                end
                WR_DATA: begin
                    rx_valid <= 1'b1;
                    din      <= {WRITE_DATA, cur_wdata};
                end
                RD_ADDR: begin
                    rx_valid <= 1'b1;
                    din      <= {STORE_RD_ADDR, cur_addr};
                end
                RD_CMD: begin
                    rx_valid <= 1'b1;
                    din      <= {READ_DATA, {ADDR_SIZE{1'b0}}};
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    if (state == RD_WAIT) begin
                        if (tx_valid) begin
                            rsp_rdata <= dout;
                        end else begin
                            rsp_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Randomized bench for ram_cmd_master against a transaction-level model of the
// command sequence, reply window and optional RAM_CMD_ADDR_CACHE_EN address cache.
module tb_ram_cmd_master;

    localparam int AW = 8;
    localparam int T  = 16;
`ifdef RAM_CMD_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [AW-1:0] rsp_rdata;
    logic          rx_valid;
    logic [AW+1:0] din;
    logic          tx_valid;
    logic [AW-1:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] mem [256];
    bit            wc_vld, rc_vld;
    logic [AW-1:0] wc_addr, rc_addr;

    ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .rx_valid  (rx_valid),
        .din       (din),
        .tx_valid  (tx_valid),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n, input bit pulse_second);
        for (int i = 1; i <= n; i++) begin
            req_valid = 1'b0;
            tx_valid  = (pulse_second && i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            dout      = AW'($urandom);
            @(negedge clk);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_rx_valid", rx_valid, 0);
            check("idle_ready", req_ready, 1);
        end
    endtask

    // d: cycles after the READ_DATA word at which the RAM raises tx_valid (d > T means never)
    task automatic run_req(input bit we, input logic [AW-1:0] a, input logic [AW-1:0] wd,
                           input int d, input bit rst_mid);
        logic [AW+1:0] words[$];
        bit            hit, err;
        int            w, r;
        logic [AW-1:0] rd;

        if (we) begin
            hit = CACHE && wc_vld && (wc_addr == a);
            if (!hit) words.push_back({2'b00, a});
            words.push_back({2'b01, wd});
            if (!hit) begin wc_vld = 1'b1; wc_addr = a; end
        end else begin
            hit = CACHE && rc_vld && (rc_addr == a);
            if (!hit) words.push_back({2'b10, a});
            words.push_back({2'b11, {AW{1'b0}}});
            if (!hit) begin rc_vld = 1'b1; rc_addr = a; end
        end
        w   = words.size();
        err = !we && (d > T);
        if (we)          r = w + 1;
        else if (d <= T) r = w + d + 1;
        else             r = w + T + 1;
        rd = (we || err) ? '0 : mem[a];

        @(negedge clk);
        check("accept_ready", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        tx_valid  = 1'($urandom_range(0, 1));
        dout      = AW'($urandom);

        for (int k = 1; k <= r; k++) begin
            @(negedge clk);
            check("busy_ready", req_ready, 0);
            check("rx_valid", rx_valid, (k <= w) ? 1 : 0);
            check("din", din, (k <= w) ? 32'(words[k-1]) : 32'd0);
            check("rsp_valid", rsp_valid, (k == r) ? 1 : 0);
            if (k == r) begin
                check("rsp_err", rsp_err, err);
                check("rsp_rdata", rsp_rdata, rd);
            end
            if (rst_mid && k == w + 3) begin
                rst       = 1'b1;
                req_valid = 1'b0;
                tx_valid  = 1'b1;
                @(negedge clk);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rx_valid", rx_valid, 0);
                check("rst_din", din, 0);
                check("rst_ready", req_ready, 0);
                rst      = 1'b0;
                tx_valid = 1'b0;
                #1;
                check("post_rst_ready", req_ready, 1);
                wc_vld = 1'b0;
                rc_vld = 1'b0;
                return;
            end
            req_valid = (k < r) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = AW'($urandom);
            if (!we && k > w && k < r) begin
                tx_valid = (k == w + d);
                dout     = (k == w + d) ? mem[a] : AW'($urandom);
            end else begin
                tx_valid = 1'($urandom_range(0, 1));
                dout     = AW'($urandom);
            end
        end
        if (we) mem[a] = wd;

        @(negedge clk);
        check("done_rsp_valid", rsp_valid, 0);
        check("done_rx_valid", rx_valid, 0);
        check("done_ready", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = AW'($urandom);
        wc_vld = 1'b0;
        rc_vld = 1'b0;

        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h3C;
        req_wdata = 8'hA5;
        tx_valid  = 1'b0;
        dout      = '0;
        repeat (5) begin
            @(negedge clk);
            check("reset_ready", req_ready, 0);
            check("reset_rx_valid", rx_valid, 0);
            check("reset_din", din, 0);
            check("reset_rsp_valid", rsp_valid, 0);
        end
        req_valid = 1'b0;
        rst       = 1'b0;

        run_req(1'b1, 8'h3C, 8'hA5, 0, 1'b0);
        run_req(1'b0, 8'h3C, 8'h00, 1, 1'b0);
        run_req(1'b0, 8'h55, 8'h00, T + 4, 1'b0);
        idle(3, 1'b1);
        run_req(1'b0, 8'h77, 8'h00, T + 4, 1'b1);
        run_req(1'b1, 8'h10, 8'h21, 0, 1'b0);
        run_req(1'b1, 8'h10, 8'h42, 0, 1'b0);
        run_req(1'b0, 8'h10, 8'h00, T, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            run_req(1'($urandom_range(0, 1)), a, AW'($urandom), $urandom_range(1, T + 3), 1'b0);
            idle($urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
